// File: rtl/cordiv_seq.sv
`default_nettype none
// ============================================================================
// cordiv_seq : unipolar stochastic CORDIV sequencer (LFSR stream generation,
//              warm-up flush, quotient counting). Optional abort input is
//              enabled by defining CORDIV_SEQ_ABORT_EN.
// Revision   : 1.0
// ============================================================================
module cordiv_seq #(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      LOGLEN = 8,
    parameter int unsigned      WARMUP = 4,
    parameter logic [WIDTH-1:0] SEED_A = 'h5A,
    parameter logic [WIDTH-1:0] SEED_B = 'hC3
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CORDIV_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_dividend,
    input  logic [WIDTH-1:0]  in_divisor,
    input  logic              in_sel,
    output logic              cd_sel,
    output logic              cd_dividend,
    output logic              cd_divisor,
    input  logic              cd_quotient,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGLEN:0]   out_quotient,
    output logic              out_dz,
    output logic              busy
);

    localparam logic [WIDTH-1:0]  POLY      = (WIDTH == 16) ? WIDTH'(32'hB400) : WIDTH'(32'hB8);
    localparam int                WARM_W    = $clog2(WARMUP + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP);
    localparam logic [LOGLEN-1:0] RUN_LAST  = '1;
    localparam logic [LOGLEN:0]   FULL      = {1'b1, {LOGLEN{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [WIDTH-1:0]  lfsr_a_q,   lfsr_a_d;
    logic [WIDTH-1:0]  lfsr_b_q,   lfsr_b_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  divisor_q,  divisor_d;
    logic              sel_q,      sel_d;
    logic [WARM_W-1:0] warm_q,     warm_d;
    logic [LOGLEN-1:0] run_q,      run_d;
    logic [LOGLEN:0]   acc_q,      acc_d;
    logic              dz_q,       dz_d;
    logic              active;

    // Right-shifting Galois form; POLY holds the non-constant polynomial terms.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    assign active       = (state_q == WARM) || (state_q == RUN);
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign busy         = active;
    assign cd_sel       = sel_q;
    assign cd_dividend  = active && (lfsr_a_q < dividend_q);
    assign cd_divisor   = active && (lfsr_b_q < divisor_q);
    assign out_quotient = acc_q;
    assign out_dz       = dz_q;

    always_comb begin
        state_d    = state_q;
        lfsr_a_d   = lfsr_a_q;
        lfsr_b_d   = lfsr_b_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sel_d      = sel_q;
        warm_d     = warm_q;
        run_d      = run_q;
        acc_d      = acc_q;
        dz_d       = dz_q;

        if (active) begin
            lfsr_a_d = lfsr_step(lfsr_a_q);
            lfsr_b_d = lfsr_step(lfsr_b_q);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dividend_d = in_dividend;
                    divisor_d  = in_divisor;
                    sel_d      = in_sel;
                    warm_d     = '0;
                    run_d      = '0;
                    acc_d      = '0;
                    dz_d       = 1'b0;
                    if (in_divisor == '0) begin
                        acc_d   = FULL;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WARM;
                    end
                end
            end
            WARM: begin
                // Only divisor-one cycles shift the divider, so only they flush it.
                if (cd_divisor) begin
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_d == WARM_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_q + (LOGLEN + 1)'(cd_quotient);
                run_d = run_q + LOGLEN'(1);
                if (run_q == RUN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CORDIV_SEQ_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_a_q   <= SEED_A;
            lfsr_b_q   <= SEED_B;
            dividend_q <= '0;
            divisor_q  <= '0;
            sel_q      <= 1'b0;
            warm_q     <= '0;
            run_q      <= '0;
            acc_q      <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_a_q   <= lfsr_a_d;
            lfsr_b_q   <= lfsr_b_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sel_q      <= sel_d;
            warm_q     <= warm_d;
            run_q      <= run_d;
            acc_q      <= acc_d;
            dz_q       <= dz_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordiv_seq.sv
`default_nettype none
// ============================================================================
// tb_cordiv_seq : directed + randomized bench for cordiv_seq with a CORDIV
//                 divider (depth-2 shift register) and a stream-level model.
// Revision      : 1.0
// ============================================================================
module tb_cordiv_seq;

    localparam int WIDTH  = 8;
    localparam int LOGLEN = 8;
    localparam int WARMUP = 4;
    localparam int STREAM = 1 << LOGLEN;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_dividend;
    logic [WIDTH-1:0]  in_divisor;
    logic              in_sel;
    logic              cd_sel;
    logic              cd_dividend;
    logic              cd_divisor;
    logic              cd_quotient;
    logic              out_valid;
    logic              out_ready;
    logic [LOGLEN:0]   out_quotient;
    logic              out_dz;
    logic              busy;
`ifdef CORDIV_SEQ_ABORT_EN
    logic              abort;
    initial abort = 1'b0;
`endif

    cordiv_seq #(
        .WIDTH  (WIDTH),
        .LOGLEN (LOGLEN),
        .WARMUP (WARMUP),
        .SEED_A (8'h5A),
        .SEED_B (8'hC3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef CORDIV_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_sel       (in_sel),
        .cd_sel       (cd_sel),
        .cd_dividend  (cd_dividend),
        .cd_divisor   (cd_divisor),
        .cd_quotient  (cd_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_dz       (out_dz),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External CORDIV divider: quotient follows the dividend when the divisor
    // bit is 1 (and that bit is stored), otherwise replays a stored bit.
    logic [1:0] div_sr;
    assign cd_quotient = cd_divisor ? cd_dividend : div_sr[cd_sel];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          div_sr <= 2'b00;
        else if (cd_divisor) div_sr <= {div_sr[0], cd_dividend};
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Stream-level reference state
    logic [7:0] m_la, m_lb;
    logic [1:0] m_sr;
    int         exp_q, exp_dz, exp_lat, exp_warm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        // x^8+x^6+x^5+x^4+1
        return (x >> 1) ^ ((x & 8'h01) != 0 ? 8'hB8 : 8'h00);
    endfunction

    task automatic model_reset();
        m_la = 8'h5A;
        m_lb = 8'hC3;
        m_sr = 2'b00;
    endtask

    task automatic model_op(input int dvd, input int dvs, input int sel);
        int warm, cyc, acc, a, b, q;
        if (dvs == 0) begin
            exp_q = STREAM; exp_dz = 1; exp_lat = 1; exp_warm = 0;
            return;
        end
        warm = 0; cyc = 0; acc = 0;
        while (warm < WARMUP) begin
            a = (int'(m_la) < dvd) ? 1 : 0;
            b = (int'(m_lb) < dvs) ? 1 : 0;
            if (b == 1) begin
                m_sr = {m_sr[0], a[0]};
                warm++;
            end
            m_la = lfsr_next(m_la);
            m_lb = lfsr_next(m_lb);
            cyc++;
        end
        for (int k = 0; k < STREAM; k++) begin
            a = (int'(m_la) < dvd) ? 1 : 0;
            b = (int'(m_lb) < dvs) ? 1 : 0;
            q = (b == 1) ? a : int'(m_sr[sel]);
            acc += q;
            if (b == 1) m_sr = {m_sr[0], a[0]};
            m_la = lfsr_next(m_la);
            m_lb = lfsr_next(m_lb);
        end
        exp_q = acc; exp_dz = 0; exp_warm = cyc; exp_lat = cyc + STREAM + 1;
    endtask

    task automatic accept(input int dvd, input int dvs, input int sel);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_dividend = 8'(dvd);
        in_divisor  = 8'(dvs);
        in_sel      = sel[0];
        @(negedge clk);
        in_valid = 1'b0;
        model_op(dvd, dvs, sel);
    endtask

    task automatic wait_result(input string tag);
        int cyc = 1;
        while (out_valid !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_quotient"}, 32'(out_quotient), 32'(exp_q));
        check({tag, "_dz"}, 32'(out_dz), 32'(exp_dz));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic stall(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_quot"}, 32'(out_quotient), 32'(exp_q));
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_taken_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_taken_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cd"}, 32'({cd_sel, cd_dividend, cd_divisor}), 32'd0);
        check({tag, "_quot"}, 32'(out_quotient), 32'd0);
        check({tag, "_dz"}, 32'(out_dz), 32'd0);
    endtask

    initial begin
        int first_q;
        int dvd, dvs, sel;
        rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
        in_sel = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: nothing moves, LFSRs hold (confirmed by later bit-exact runs)
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(in_ready), 32'd1);
            check("idle_cd", 32'({out_valid, cd_dividend, cd_divisor, busy}), 32'd0);
        end

        // Divide by zero: one-cycle path, held while stalled
        accept(100, 0, 0);
        check("dz_valid_1cyc", 32'(out_valid), 32'd1);
        wait_result("dz");
        stall("dz", 5);
        take("dz");

        // Ratio 64/128 from the reset seeds (reference for the reset test)
        accept(64, 128, 0);
        first_q = exp_q;
        wait_result("ratio_sel0");
        take("ratio_sel0");

        accept(64, 128, 1);
        wait_result("ratio_sel1");
        take("ratio_sel1");

        // Zero dividend gives an exact zero count
        accept(0, 128, 0);
        wait_result("zero_dvd");
        check("zero_dvd_exact", 32'(out_quotient), 32'd0);
        take("zero_dvd");

        // Back-to-back with a stalled result and a pending next operand
        accept(200, 50, 0);
        wait_result("b2b_first");
        in_valid = 1'b1; in_dividend = 8'd30; in_divisor = 8'd90; in_sel = 1'b1;
        stall("b2b", 20);
        take("b2b");
        accept(30, 90, 1);
        wait_result("b2b_second");
        take("b2b_second");

        // Randomized operations, LFSR sequence continuing
        for (int i = 0; i < 5; i++) begin
            dvd = int'($urandom_range(0, 255));
            dvs = (i == 2) ? 0 : int'($urandom_range(1, 255));
            sel = int'($urandom_range(0, 1));
            accept(dvd, dvs, sel);
            wait_result("rand");
            stall("rand", int'($urandom_range(0, 3)));
            take("rand");
        end

        // Asynchronous reset 100 cycles into RUN
        accept(64, 128, 1);
        repeat (exp_warm + 100) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        accept(64, 128, 0);
        wait_result("fresh");
        check("fresh_vs_first", 32'(out_quotient), 32'(first_q));
        take("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
